card_reader_validator: RTL

- Card-reader side of the door access path: receives a Wiegand-style serial frame from the badge reader, checks parity, and looks up the card ID in a small programmable allow-list.
- Drives the registered `card_valid` level consumed by the door controller, and pulses `card_denied` or `frame_err` on a failed read.
- Sits between the reader front-end (one bit per strobe, already synchronised to `clk`) and the door controller.

---
 rtl/card_reader_validator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/card_reader_validator.sv
// Wiegand-style card frame receiver: parity check, allow-list search, and
// grant/deny/error reporting towards the door controller.
module card_reader_validator #(
    parameter int ID_W        = 24,
    parameter int NUM_IDS     = 8,
    parameter int ADDR_W      = 3,
    parameter int TIMEOUT     = 1000,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_strobe,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [ID_W-1:0]   prog_id,
    input  logic              prog_en,
    output logic              card_valid,
    output logic              card_denied,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_W = ID_W + 2;
    localparam int HALF    = ID_W / 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        SEARCH,
        GRANT,
        DENY
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic [ADDR_W-1:0]   idx, idx_d;
    logic [FRAME_W-1:0]  shift_reg, shift_reg_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                card_valid_d, card_denied_d, frame_err_d;

    logic [ID_W-1:0]     ids [NUM_IDS];
    logic [NUM_IDS-1:0]  id_en;

    logic [ID_W-1:0]     rx_id;
    logic                parity_ok;
    logic                entry_match;
    logic                prog_hit;

    // Frame layout after the last shift: {even parity, ID, odd parity}.
    assign rx_id     = shift_reg[ID_W:1];
    assign parity_ok = ~(shift_reg[FRAME_W-1] ^ (^rx_id[ID_W-1:HALF]))
                     &  (shift_reg[0] ^ (^rx_id[HALF-1:0]));

    assign entry_match = id_en[idx] && (ids[idx] == id_q);
    assign prog_hit    = prog_we && ({1'b0, prog_addr} < (ADDR_W + 1)'(NUM_IDS));
    assign busy        = (state != IDLE) && (state != RECV);

    // NOTE: the ID storage has no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (prog_hit) begin
            ids[prog_addr] <= prog_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_en <= '0;
        end else if (prog_hit) begin
            id_en[prog_addr] <= prog_en;
        end
    end

    // NOTE: every signal is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state;
        bit_cnt_d     = bit_cnt;
        gap_cnt_d     = gap_cnt;
        hold_cnt_d    = hold_cnt;
        idx_d         = idx;
        shift_reg_d   = shift_reg;
        id_d          = id_q;
        card_valid_d  = 1'b0;
        card_denied_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state)
            IDLE: begin
                gap_cnt_d = '0;
                if (bit_strobe) begin
                    shift_reg_d = {shift_reg[FRAME_W-2:0], bit_in};
                    bit_cnt_d   = CNT_W'(1);
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (bit_strobe) begin
                    shift_reg_d = {shift_reg[FRAME_W-2:0], bit_in};
                    gap_cnt_d   = '0;
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end else if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    gap_cnt_d   = '0;
                    state_d     = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            CHECK: begin
                if (parity_ok) begin
                    id_d    = rx_id;
                    idx_d   = '0;
                    state_d = SEARCH;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            SEARCH: begin
                if (entry_match) begin
                    card_valid_d = 1'b1;
                    hold_cnt_d   = '0;
                    state_d      = GRANT;
                end else if (idx == ADDR_W'(NUM_IDS - 1)) begin
                    card_denied_d = 1'b1;
                    state_d       = DENY;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            GRANT: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    card_valid_d = 1'b1;
                    hold_cnt_d   = hold_cnt + 1'b1;
                end
            end
            DENY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            hold_cnt    <= '0;
            idx         <= '0;
            shift_reg   <= '0;
            id_q        <= '0;
            card_valid  <= 1'b0;
            card_denied <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            gap_cnt     <= gap_cnt_d;
            hold_cnt    <= hold_cnt_d;
            idx         <= idx_d;
            shift_reg   <= shift_reg_d;
            id_q        <= id_d;
            card_valid  <= card_valid_d;
            card_denied <= card_denied_d;
            frame_err   <= frame_err_d;
        end
    end

endmodule
